task_menu_selector: RTL and testbench
=====================================

# task_menu_selector

Front-end control stage feeding the integrated task controller that drives the OLED pixel stream. It debounces btnL/btnC/btnR, runs a MENU/RUN state machine that selects one of four tasks (P, Q, R, S), and forwards clean single-cycle button pulses to the active task. While no task is running, it renders the selection menu as 16-bit RGB565 pixel data for the shared `pixel_index` bus.

## Interface
- `DEBOUNCE_CYCLES`, default 200_000: consecutive stable cycles required to accept a button level (2 ms at 100 MHz).
- `LONG_CYCLES`, default 100_000_000: btnC hold length that exits a running task (1 s).
- `clk` in 1: 100 MHz system clock.
- `reset_n` in 1: asynchronous active-low reset.
- `btnL`, `btnC`, `btnR` in 1 each: raw, asynchronous push-button levels.
- `pixel_index` in 13: OLED pixel address, 0..6143, row-major over 96x64.
- `task_sel` out 2: selected task, 0=P 1=Q 2=R 3=S.
- `task_active` out 1: high in RUN.
- `btnL_pulse`, `btnC_pulse`, `btnR_pulse` out 1 each: one-cycle press pulses, RUN only.
- `menu_pixel` out 16: menu pixel colour for `pixel_index`.

## Operation
- Reset values: state MENU, `task_sel`=0, `task_active`=0, all pulses 0, `menu_pixel`=0. Debounced levels and all counters are 0.
- Debounce, per button:
  - Two-flop synchroniser into `sync`.
  - A counter increments while `sync` != `stable` and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, `stable` takes `sync` and the counter clears.
  - `press` is a one-cycle internal event on a `stable` 0->1 transition. A glitch shorter than DEBOUNCE_CYCLES produces no event.
- MENU:
  - L press: `task_sel` decrements, 0 wraps to 3.
  - R press: `task_sel` increments, 3 wraps to 0.
  - L and R press in the same cycle: no change.
  - C press: go to RUN. This press is not forwarded and does not arm the long-hold counter.
  - All `*_pulse` outputs are held at 0.
- RUN:
  - `task_sel` is frozen.
  - Each press produces its matching `*_pulse`.
  - A C press arms the hold counter. The counter clears and disarms when C `stable` falls.
  - When the armed counter reaches LONG_CYCLES: go to MENU and clear the counter. The still-held C and its later release have no effect.
  - Simultaneous presses each pulse independently.
- Menu render:
  - `pixel_index` < 1536 maps to row 0, < 3072 to row 1, < 4608 to row 2, < 6144 to row 3. No divider is used; thresholds are compared directly.
  - Row equal to `task_sel`: 16'h07E0 (green). Other rows: 16'h8410 (grey).
  - Pixels with x column 0 or 95 (index mod 96), and `pixel_index` >= 6144: 16'h0000.
  - Output is registered and computed in RUN as well. The downstream mux decides which source to use.
- Counters saturate rather than wrap. Widths are $clog2 of the corresponding parameter plus 1.

## Timing
- Raw edge at cycle t: `sync` changes at t+2, `stable` at t+2+DEBOUNCE_CYCLES, and the press is acted on at t+3+DEBOUNCE_CYCLES.
- A press in MENU updates `task_sel` / `task_active` on the press-event cycle.
- A RUN pulse is registered and asserted in the cycle after the press event, for exactly 1 cycle.
- Long-hold exit: `task_active` falls LONG_CYCLES cycles after the arming press event.
- `menu_pixel` has 1-cycle latency from `pixel_index`. This is well inside one 6.25 MHz OLED sample period.
- Reset asserted mid-operation, e.g. in RUN or mid-debounce: all state returns to its reset values immediately. There is no pulse on deassertion, even if a button is held: `stable` starts at 0 and a held button yields one press DEBOUNCE_CYCLES+3 cycles after release of reset.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and LONG_CYCLES=20.
- Bounce: btnR toggles with a 2-cycle period for 10 cycles, then stays high. Required: exactly one `task_sel` increment, 0->1, exactly 7 cycles after the final rising edge. 3-cycle glitches produce nothing.
- Wrap: from reset, L press gives `task_sel`=3. Then four R presses give 0,1,2,3, and a fifth gives 0. L+R pressed in the same cycle: unchanged.
- Enter/forward: with `task_sel`=2, press C, then `task_active`=1 and `btnC_pulse` stays 0. Then an L press gives `btnL_pulse` high for 1 cycle with `task_sel` still 2, and a short C press (10 cycles) gives one `btnC_pulse` and stays in RUN.
- Long hold: in RUN, hold C for 30 cycles. Required: one `btnC_pulse`, then `task_active` drops 20 cycles after the press event. Release and wait 10 cycles: still MENU. The next C press re-enters RUN.
- Render: `task_sel`=1. Index 1700 gives 07E0, index 100 gives 8410, index 96 (x=0) gives 0000, index 6143 (x=95) gives 0000, index 7000 gives 0000. Each value appears 1 cycle after the index is applied.
- Reset mid-RUN with btnC held: `reset_n` low for 3 cycles. Required: all outputs at reset values, and a single C press event occurs 7 cycles after release, returning to RUN with `task_sel`=0.

Source files
------------

// File: rtl/task_menu_selector.sv
// Front-end control for the task controller: debounces the three buttons, picks
// one of four tasks in MENU, forwards press pulses in RUN, and renders the menu.
module task_menu_selector #(
    parameter int unsigned DEBOUNCE_CYCLES = 200_000,
    parameter int unsigned LONG_CYCLES     = 100_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btnL,
    input  logic        btnC,
    input  logic        btnR,
    input  logic [12:0] pixel_index,
    output logic [1:0]  task_sel,
    output logic        task_active,
    output logic        btnL_pulse,
    output logic        btnC_pulse,
    output logic        btnR_pulse,
    output logic [15:0] menu_pixel
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES) + 1;
    localparam int unsigned NBTN   = 3;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    localparam logic [1:0] BTN_L = 2'd0;
    localparam logic [1:0] BTN_C = 2'd1;
    localparam logic [1:0] BTN_R = 2'd2;

    localparam logic [12:0] ROW1_START = 13'd1536;
    localparam logic [12:0] ROW2_START = 13'd3072;
    localparam logic [12:0] ROW3_START = 13'd4608;
    localparam logic [12:0] PIX_END    = 13'd6144;
    localparam logic [12:0] COLS       = 13'd96;
    localparam logic [6:0]  COL_LAST   = 7'd95;

    localparam logic [15:0] PIX_SEL  = 16'h07E0;
    localparam logic [15:0] PIX_IDLE = 16'h8410;
    localparam logic [15:0] PIX_OFF  = 16'h0000;

    typedef enum logic {
        ST_MENU = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic [NBTN-1:0] w_raw;
    logic [NBTN-1:0] w_stable;
    logic [NBTN-1:0] w_press;

    assign w_raw = {btnR, btnC, btnL};

    // Per-button synchroniser + debounce; press fires on the accepted 0->1 edge
    for (genvar g = 0; g < NBTN; g++) begin : g_btn
        logic            r_meta;
        logic            r_sync;
        logic            r_stable;
        logic            r_stable_d;
        logic [DB_W-1:0] r_cnt;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_meta     <= 1'b0;
                r_sync     <= 1'b0;
                r_stable   <= 1'b0;
                r_stable_d <= 1'b0;
                r_cnt      <= '0;
            end else begin
                r_meta     <= w_raw[g];
                r_sync     <= r_meta;
                r_stable_d <= r_stable;
                if (r_sync == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt >= DB_LAST) begin
                    r_stable <= r_sync;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_stable[g] = r_stable;
        assign w_press[g]  = r_stable & ~r_stable_d;
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_sel;
    logic [1:0]        w_sel_nxt;
    logic              r_armed;
    logic              w_armed_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [NBTN-1:0]   r_pulse;
    logic [NBTN-1:0]   w_pulse_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_MENU;
            r_sel      <= 2'd0;
            r_armed    <= 1'b0;
            r_hold_cnt <= '0;
            r_pulse    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_armed    <= w_armed_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_pulse    <= w_pulse_nxt;
        end
    end

    // Menu navigation, run entry, press forwarding and long-hold exit
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_armed_nxt = r_armed;
        w_hold_nxt  = r_hold_cnt;
        w_pulse_nxt = '0;
        case (r_state)
            ST_MENU: begin
                w_armed_nxt = 1'b0;
                w_hold_nxt  = '0;
                if (w_press[BTN_L] && !w_press[BTN_R]) begin
                    w_sel_nxt = r_sel - 2'd1;
                end else if (w_press[BTN_R] && !w_press[BTN_L]) begin
                    w_sel_nxt = r_sel + 2'd1;
                end
                if (w_press[BTN_C]) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_pulse_nxt = w_press;
                if (!w_stable[BTN_C]) begin
                    w_armed_nxt = 1'b0;
                    w_hold_nxt  = '0;
                end else if (w_press[BTN_C]) begin
                    w_armed_nxt = 1'b1;
                    w_hold_nxt  = '0;
                end else if (r_armed) begin
                    if (r_hold_cnt >= HOLD_LAST) begin
                        w_state_nxt = ST_MENU;
                        w_armed_nxt = 1'b0;
                        w_hold_nxt  = '0;
                    end else begin
                        w_hold_nxt = r_hold_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_MENU;
            end
        endcase
    end

    logic [1:0]  w_row;
    logic [6:0]  w_col;
    logic [15:0] w_pix_nxt;
    logic [15:0] r_menu_pixel;

    // Row from direct threshold compares; border columns and off-screen are black
    always_comb begin
        w_col = 7'(pixel_index % COLS);
        if (pixel_index < ROW1_START) begin
            w_row = 2'd0;
        end else if (pixel_index < ROW2_START) begin
            w_row = 2'd1;
        end else if (pixel_index < ROW3_START) begin
            w_row = 2'd2;
        end else begin
            w_row = 2'd3;
        end
        if (pixel_index >= PIX_END || w_col == 7'd0 || w_col == COL_LAST) begin
            w_pix_nxt = PIX_OFF;
        end else if (w_row == r_sel) begin
            w_pix_nxt = PIX_SEL;
        end else begin
            w_pix_nxt = PIX_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_menu_pixel <= PIX_OFF;
        end else begin
            r_menu_pixel <= w_pix_nxt;
        end
    end

    assign task_sel    = r_sel;
    assign task_active = (r_state == ST_RUN);
    assign btnL_pulse  = r_pulse[BTN_L];
    assign btnC_pulse  = r_pulse[BTN_C];
    assign btnR_pulse  = r_pulse[BTN_R];
    assign menu_pixel  = r_menu_pixel;

endmodule

// File: tb/tb_task_menu_selector.sv
// Bench for task_menu_selector: directed scenarios plus random button traffic
// compared against a cycle-level behavioural model.
module tb_task_menu_selector;

    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        btnL = 1'b0;
    logic        btnC = 1'b0;
    logic        btnR = 1'b0;
    logic [12:0] pixel_index = 13'd0;
    logic [1:0]  task_sel;
    logic        task_active;
    logic        btnL_pulse;
    logic        btnC_pulse;
    logic        btnR_pulse;
    logic [15:0] menu_pixel;

    int n_checks = 0;
    int n_fail   = 0;

    task_menu_selector #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES(LONG)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .btnL(btnL),
        .btnC(btnC),
        .btnR(btnR),
        .pixel_index(pixel_index),
        .task_sel(task_sel),
        .task_active(task_active),
        .btnL_pulse(btnL_pulse),
        .btnC_pulse(btnC_pulse),
        .btnR_pulse(btnR_pulse),
        .menu_pixel(menu_pixel)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    bit          m_h1[3];
    bit          m_h2[3];
    bit          m_lvl[3];
    bit          m_rose[3];
    bit          m_ev[3];
    bit          m_raw[3];
    int          m_streak[3];
    bit          m_run = 1'b0;
    int          m_sel = 0;
    int          m_arm = -1;
    int          m_cyc = 0;
    logic [2:0]  m_pulse = 3'b000;
    logic [15:0] m_pix = 16'h0000;

    function automatic logic [15:0] exp_pixel(input int idx, input int sel);
        int x;
        int row;
        if (idx >= 6144) return 16'h0000;
        x = idx % 96;
        if (x == 0 || x == 95) return 16'h0000;
        row = idx / 1536;
        return (row == sel) ? 16'h07E0 : 16'h8410;
    endfunction

    task automatic model_step();
        if (!reset_n) begin
            for (int b = 0; b < 3; b++) begin
                m_h1[b] = 0; m_h2[b] = 0; m_lvl[b] = 0; m_rose[b] = 0; m_streak[b] = 0;
            end
            m_run = 0; m_sel = 0; m_arm = -1; m_pulse = 3'b000; m_pix = 16'h0000;
        end else begin
            m_raw[0] = btnL; m_raw[1] = btnC; m_raw[2] = btnR;
            for (int b = 0; b < 3; b++) m_ev[b] = m_rose[b];
            m_pix   = exp_pixel(int'(pixel_index), m_sel);
            m_pulse = m_run ? {m_ev[2], m_ev[1], m_ev[0]} : 3'b000;
            if (!m_run) begin
                if (m_ev[0] && !m_ev[2]) m_sel = (m_sel + 3) % 4;
                else if (m_ev[2] && !m_ev[0]) m_sel = (m_sel + 1) % 4;
                if (m_ev[1]) begin m_run = 1; m_arm = -1; end
            end else begin
                if (!m_lvl[1]) m_arm = -1;
                else if (m_ev[1]) m_arm = m_cyc;
                else if (m_arm >= 0 && (m_cyc - m_arm) == LONG) begin
                    m_run = 0; m_arm = -1;
                end
            end
            // a level is accepted once the synchronised input disagrees for DEB samples
            for (int b = 0; b < 3; b++) begin
                m_rose[b] = 0;
                if (m_h2[b] != m_lvl[b]) begin
                    m_streak[b]++;
                    if (m_streak[b] == DEB) begin
                        m_lvl[b]    = m_h2[b];
                        m_streak[b] = 0;
                        m_rose[b]   = m_lvl[b];
                    end
                end else begin
                    m_streak[b] = 0;
                end
                m_h2[b] = m_h1[b];
                m_h1[b] = m_raw[b];
            end
            m_cyc++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            model_step();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       btnL = v;
            1:       btnC = v;
            default: btnR = v;
        endcase
    endtask

    task automatic press_btn(input int b, input int hold);
        set_btn(b, 1'b1);
        repeat (hold) tick();
        set_btn(b, 1'b0);
        repeat (12) tick();
    endtask

    task automatic do_reset();
        btnL = 0; btnC = 0; btnR = 0;
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (2) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        pixel_index = 13'd1700;
        repeat (3) tick();
        n_checks++;
        if (task_sel !== 2'd0 || task_active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state sel=%0d active=%0b, expected 0/0", task_sel, task_active);
        end
        n_checks++;
        if ({btnL_pulse, btnC_pulse, btnR_pulse} !== 3'b000 || menu_pixel !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_outputs pulses=%b pix=%h, expected 000/0000",
                     {btnL_pulse, btnC_pulse, btnR_pulse}, menu_pixel);
        end
        reset_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 10; i++) begin
            btnR = (i % 2 == 0);
            tick();
        end
        btnR = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_checks++;
            if (task_sel !== ((k < 7) ? 2'd0 : 2'd1)) begin
                n_fail++;
                $display("FAIL bounce_sel k=%0d got=%0d expected=%0d", k, task_sel, (k < 7) ? 0 : 1);
            end
        end
        repeat (3) tick();
        btnR = 1'b0;
        repeat (12) tick();
        n_checks++;
        if (task_sel !== 2'd1) begin
            n_fail++;
            $display("FAIL bounce_single got=%0d expected=1", task_sel);
        end
        press_btn(0, 3);
        press_btn(2, 3);
        n_checks++;
        if (task_sel !== 2'd1) begin
            n_fail++;
            $display("FAIL glitch_ignored got=%0d expected=1", task_sel);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        press_btn(0, 8);
        n_checks++;
        if (task_sel !== 2'd3) begin
            n_fail++;
            $display("FAIL wrap_left got=%0d expected=3", task_sel);
        end
        for (int i = 0; i < 5; i++) begin
            press_btn(2, 8);
            n_checks++;
            if (task_sel !== 2'(i % 4)) begin
                n_fail++;
                $display("FAIL wrap_right i=%0d got=%0d expected=%0d", i, task_sel, i % 4);
            end
        end
        btnL = 1'b1; btnR = 1'b1;
        repeat (8) tick();
        btnL = 1'b0; btnR = 1'b0;
        repeat (12) tick();
        n_checks++;
        if (task_sel !== 2'd0 || task_active !== 1'b0) begin
            n_fail++;
            $display("FAIL l_plus_r sel=%0d active=%0b expected 0/0", task_sel, task_active);
        end
    endtask

    task automatic test_enter_forward();
        int cnt;
        int at_k;
        bit left_run;
        press_btn(2, 8);
        press_btn(2, 8);
        n_checks++;
        if (task_sel !== 2'd2) begin
            n_fail++;
            $display("FAIL enter_presel got=%0d expected=2", task_sel);
        end
        set_btn(1, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 8) set_btn(1, 1'b0);
            n_checks++;
            if (btnC_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL enter_no_cpulse k=%0d got=%0b expected=0", k, btnC_pulse);
            end
            if (k == 6 || k == 7) begin
                n_checks++;
                if (task_active !== ((k == 7) ? 1'b1 : 1'b0)) begin
                    n_fail++;
                    $display("FAIL enter_active k=%0d got=%0b expected=%0d", k, task_active, k == 7);
                end
            end
        end
        cnt = 0; at_k = -1;
        set_btn(0, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 8) set_btn(0, 1'b0);
            if (btnL_pulse === 1'b1) begin cnt++; at_k = k; end
        end
        n_checks++;
        if (cnt != 1 || at_k != 7) begin
            n_fail++;
            $display("FAIL fwd_lpulse count=%0d at=%0d expected count=1 at=7", cnt, at_k);
        end
        n_checks++;
        if (task_sel !== 2'd2) begin
            n_fail++;
            $display("FAIL fwd_sel_frozen got=%0d expected=2", task_sel);
        end
        cnt = 0; left_run = 0;
        set_btn(1, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 10) set_btn(1, 1'b0);
            if (btnC_pulse === 1'b1) cnt++;
            if (task_active !== 1'b1) left_run = 1;
        end
        n_checks++;
        if (cnt != 1 || left_run) begin
            n_fail++;
            $display("FAIL short_c pulses=%0d left_run=%0b expected 1/0", cnt, left_run);
        end
    endtask

    task automatic test_long_hold();
        int cnt;
        int drop_k;
        cnt = 0; drop_k = -1;
        set_btn(1, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (btnC_pulse === 1'b1) cnt++;
            if (drop_k < 0 && task_active === 1'b0) drop_k = k;
        end
        set_btn(1, 1'b0);
        n_checks++;
        if (cnt != 1) begin
            n_fail++;
            $display("FAIL long_cpulse count=%0d expected=1", cnt);
        end
        n_checks++;
        if (drop_k != 27) begin
            n_fail++;
            $display("FAIL long_exit drop_cycle=%0d expected=27", drop_k);
        end
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_checks++;
            if (task_active !== 1'b0) begin
                n_fail++;
                $display("FAIL long_release k=%0d active=%0b expected=0", k, task_active);
            end
        end
        press_btn(1, 8);
        n_checks++;
        if (task_active !== 1'b1 || task_sel !== 2'd2) begin
            n_fail++;
            $display("FAIL long_reenter active=%0b sel=%0d expected 1/2", task_active, task_sel);
        end
    endtask

    task automatic test_render();
        int          idx[6];
        logic [15:0] exp[6];
        idx = '{1700, 100, 96, 6143, 7000, 3100};
        exp = '{16'h07E0, 16'h8410, 16'h0000, 16'h0000, 16'h0000, 16'h8410};
        do_reset();
        press_btn(2, 8);
        pixel_index = 13'd0;
        tick();
        for (int i = 0; i < 6; i++) begin
            pixel_index = 13'(idx[i]);
            tick();
            n_checks++;
            if (menu_pixel !== exp[i]) begin
                n_fail++;
                $display("FAIL render idx=%0d got=%h expected=%h", idx[i], menu_pixel, exp[i]);
            end
        end
        press_btn(1, 8);
        pixel_index = 13'd1700;
        tick();
        n_checks++;
        if (menu_pixel !== 16'h07E0 || task_active !== 1'b1) begin
            n_fail++;
            $display("FAIL render_run pix=%h active=%0b expected 07E0/1", menu_pixel, task_active);
        end
        pixel_index = 13'd5000;
        tick();
        n_checks++;
        if (menu_pixel !== 16'h8410) begin
            n_fail++;
            $display("FAIL render_run_row3 got=%h expected=8410", menu_pixel);
        end
    endtask

    task automatic test_reset_mid_run();
        set_btn(1, 1'b1);
        repeat (10) tick();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (task_sel !== 2'd0 || task_active !== 1'b0 || menu_pixel !== 16'h0000 ||
            {btnL_pulse, btnC_pulse, btnR_pulse} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrun_reset sel=%0d active=%0b pix=%h pulses=%b expected all 0",
                     task_sel, task_active, menu_pixel, {btnL_pulse, btnC_pulse, btnR_pulse});
        end
        repeat (3) tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_checks++;
            if ({btnL_pulse, btnC_pulse, btnR_pulse} !== 3'b000) begin
                n_fail++;
                $display("FAIL midrun_no_pulse k=%0d pulses=%b expected 000", k,
                         {btnL_pulse, btnC_pulse, btnR_pulse});
            end
            if (k == 6 || k == 7) begin
                n_checks++;
                if (task_active !== ((k == 7) ? 1'b1 : 1'b0) || task_sel !== 2'd0) begin
                    n_fail++;
                    $display("FAIL midrun_reenter k=%0d active=%0b sel=%0d expected %0d/0",
                             k, task_active, task_sel, k == 7);
                end
            end
        end
        set_btn(1, 1'b0);
        repeat (12) tick();
    endtask

    task automatic test_random();
        int          hold_left[3];
        bit          lvl[3];
        logic [21:0] got;
        logic [21:0] want;
        do_reset();
        for (int b = 0; b < 3; b++) begin hold_left[b] = 0; lvl[b] = 0; end
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold_left[b] == 0) begin
                    lvl[b]       = ($urandom_range(0, 1) == 1);
                    hold_left[b] = int'($urandom_range(1, 40));
                end
                hold_left[b]--;
                set_btn(b, lvl[b]);
            end
            pixel_index = 13'($urandom_range(0, 8191));
            tick();
            got  = {task_sel, task_active, btnR_pulse, btnC_pulse, btnL_pulse, menu_pixel};
            want = {2'(m_sel), m_run, m_pulse[2], m_pulse[1], m_pulse[0], m_pix};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL random c=%0d got sel/act/RCL/pix=%h expected=%h", c, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_wrap();
        test_enter_forward();
        test_long_hold();
        test_render();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
